rsa_datapath: RTL

- Datapath slave for the 4-bit RSA encoder/decoder.
- Executes the one-hot control strobes issued by ControlLogic: load, mul, dec, gcd, cmp, mod, pow, out, sel, inc.
- Returns the status flags H1, H4, H6, H8, H9, H12, H13, H14, H15 that the controller branches on.
- Holds p, q, n, phi, e, d and the message. Runs the multi-cycle GCD and the multi-cycle modular exponentiation.

---
 rtl/rsa_pkg.sv | 27 ++
 rtl/rsa_modexp.sv | 67 ++++++
 rtl/rsa_datapath.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// Shared widths, engine state encodings, strobe decode and a modular-multiply helper.
// Definitions only: no latency and no flow control of their own.
package rsa_pkg;

  localparam int KW = 4;
  localparam int W  = 2 * KW;

  localparam logic [W-1:0] E_START = W'(2);

  typedef enum logic [1:0] {GCD_IDLE, GCD_RUN, GCD_DONE} gcd_state_t;
  typedef enum logic [1:0] {POW_IDLE, POW_RUN, POW_DONE} pow_state_t;

  typedef enum logic [3:0] {
    OP_NONE, OP_LOAD, OP_MUL, OP_GCD, OP_MOD,
    OP_POW, OP_INC, OP_DEC, OP_CMP, OP_OUT
  } op_t;

  // Full 2W-bit product reduced mod m; a zero modulus yields 0.
  function automatic logic [W-1:0] mul_mod(input logic [W-1:0] x,
                                           input logic [W-1:0] y,
                                           input logic [W-1:0] m);
    logic [2*W-1:0] prod;
    prod = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    return (m == '0) ? '0 : W'(prod % {{W{1'b0}}, m});
  endfunction

endpackage

// File: rtl/rsa_modexp.sv
// Square-and-multiply modular exponentiation, exponent consumed LSB first.
// start to done pulse is W+1 cycles; a start while busy is dropped, no backpressure.
module rsa_modexp
  import rsa_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] base,
  input  logic [W-1:0] exponent,
  input  logic [W-1:0] modulus,
  output logic [W-1:0] acc,
  output logic         done
);

  localparam int CW = $clog2(W + 1);

  pow_state_t    state;
  logic [W-1:0]  acc_r;
  logic [W-1:0]  base_r;
  logic [W-1:0]  exp_r;
  logic [W-1:0]  mod_r;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= POW_IDLE;
      acc_r  <= '0;
      base_r <= '0;
      exp_r  <= '0;
      mod_r  <= '0;
      cnt    <= '0;
      acc    <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        POW_IDLE: begin
          if (start) begin
            // Moduli 0 and 1 have no residue other than 0, so start the accumulator there.
            acc_r  <= (modulus > W'(1)) ? W'(1) : '0;
            base_r <= (modulus == '0) ? '0 : base % modulus;
            exp_r  <= exponent;
            mod_r  <= modulus;
            cnt    <= CW'(W);
            state  <= POW_RUN;
          end
        end
        POW_RUN: begin
          if (cnt != '0) begin
            if (exp_r[0]) acc_r <= mul_mod(acc_r, base_r, mod_r);
            base_r <= mul_mod(base_r, base_r, mod_r);
            exp_r  <= exp_r >> 1;
            cnt    <= cnt - CW'(1);
          end else begin
            acc   <= acc_r;
            done  <= 1'b1;
            state <= POW_DONE;
          end
        end
        POW_DONE: state <= POW_IDLE;
        default:  state <= POW_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/rsa_datapath.sv
// RSA key/message datapath driven by one-hot controller strobes; returns branch flags.
// Single-cycle ops take effect on the strobe edge; GCD and pow run multi-cycle, no backpressure.
module rsa_datapath
  import rsa_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [KW-1:0] p_in,
  input  logic [KW-1:0] q_in,
  input  logic [W-1:0]  msg_in,
  input  logic          load,
  input  logic          mul,
  input  logic          dec,
  input  logic          gcd,
  input  logic          cmp,
  input  logic          mod,
  input  logic          pow,
  input  logic          out,
  input  logic          sel,
  input  logic          inc,
  output logic          H1,
  output logic          H4,
  output logic          H6,
  output logic          H8,
  output logic          H9,
  output logic          H12,
  output logic          H13,
  output logic          H14,
  output logic          H15,
  output logic [W-1:0]  n_out,
  output logic [W-1:0]  e_out,
  output logic [W-1:0]  d_out,
  output logic [W-1:0]  result
);

  op_t          op;
  gcd_state_t   gcd_state;

  logic [KW-1:0] p_r;
  logic [KW-1:0] q_r;
  logic [W-1:0]  msg_r;
  logic [W-1:0]  n_r;
  logic [W-1:0]  phi_r;
  logic [W-1:0]  e_r;
  logic [W-1:0]  d_r;
  logic [W-1:0]  d_cand;
  logic [W-1:0]  e_cand;
  logic [W-1:0]  result_r;
  logic [W-1:0]  gcd_a;
  logic [W-1:0]  gcd_b;
  logic [W-1:0]  pow_r;

  logic [W-1:0]  p_w;
  logic [W-1:0]  q_w;
  logic [W-1:0]  pm1;
  logic [W-1:0]  qm1;
  logic [W-1:0]  phi_next;
  logic          mod_hit;

  always_comb begin
    op = OP_NONE;
    if      (load) op = OP_LOAD;
    else if (mul)  op = OP_MUL;
    else if (gcd)  op = OP_GCD;
    else if (mod)  op = OP_MOD;
    else if (pow)  op = OP_POW;
    else if (inc)  op = OP_INC;
    else if (dec)  op = OP_DEC;
    else if (cmp)  op = OP_CMP;
    else if (out)  op = OP_OUT;
  end

  assign p_w      = {{(W-KW){1'b0}}, p_r};
  assign q_w      = {{(W-KW){1'b0}}, q_r};
  assign pm1      = p_w - W'(1);
  assign qm1      = q_w - W'(1);
  assign phi_next = pm1 * qm1;
  assign mod_hit  = (mul_mod(e_r, d_cand, phi_r) == W'(1));

  // Both searches are meaningless until phi exists, so the flags stay low with phi == 0.
  assign H6 = (phi_r != '0) && (e_cand >= phi_r);
  assign H9 = (phi_r != '0) && (d_cand == '0);

  assign n_out  = n_r;
  assign e_out  = e_r;
  assign d_out  = d_r;
  assign result = result_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gcd_state <= GCD_IDLE;
      gcd_a     <= '0;
      gcd_b     <= '0;
      e_r       <= '0;
      H1        <= 1'b0;
      H4        <= 1'b0;
    end else begin
      H1 <= 1'b0;
      case (gcd_state)
        GCD_IDLE: begin
          if (op == OP_GCD) begin
            gcd_a     <= e_cand;
            gcd_b     <= phi_r;
            gcd_state <= GCD_RUN;
          end
        end
        GCD_RUN: begin
          if (gcd_b == '0) begin
            H1        <= 1'b1;
            H4        <= (gcd_a == W'(1));
            e_r       <= e_cand;
            gcd_state <= GCD_DONE;
          end else begin
            gcd_a <= gcd_b;
            gcd_b <= gcd_a % gcd_b;
          end
        end
        GCD_DONE: gcd_state <= GCD_IDLE;
        default:  gcd_state <= GCD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_r      <= '0;
      q_r      <= '0;
      msg_r    <= '0;
      n_r      <= '0;
      phi_r    <= '0;
      d_r      <= '0;
      d_cand   <= '0;
      e_cand   <= E_START;
      result_r <= '0;
      H8       <= 1'b0;
      H13      <= 1'b0;
      H14      <= 1'b0;
      H15      <= 1'b0;
    end else begin
      case (op)
        OP_LOAD: begin
          p_r    <= p_in;
          q_r    <= q_in;
          msg_r  <= msg_in;
          d_cand <= '0;
          H14    <= 1'b0;
        end
        OP_MUL: begin
          n_r    <= p_w * q_w;
          phi_r  <= phi_next;
          d_cand <= phi_next - W'(1);
          H13    <= (p_r < KW'(2)) | (q_r < KW'(2)) | (p_r == q_r);
        end
        OP_MOD: begin
          H8 <= mod_hit;
          if (mod_hit) d_r <= d_cand;
        end
        OP_INC: if (e_cand != '1) e_cand <= e_cand + W'(1);
        OP_DEC: if (d_cand != '0) d_cand <= d_cand - W'(1);
        OP_CMP: H15 <= (msg_r < n_r);
        OP_OUT: begin
          result_r <= pow_r;
          H14      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  rsa_modexp u_modexp (
    .clk      (clk),
    .reset    (reset),
    .start    (op == OP_POW),
    .base     (msg_r),
    .exponent (sel ? d_r : e_r),
    .modulus  (n_r),
    .acc      (pow_r),
    .done     (H12)
  );

endmodule
